// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// fifo_uart_tx
// Pops 16-bit words from the FIFO read port and sends each word as two UART
// frames, low byte first. One I_CLK cycle is one bit time.
// Rev 1.0
// ============================================================================
module fifo_uart_tx #(
  parameter int WR_DATA_WIDTH = 16
) (
  input  logic                     I_CLK,
  input  logic                     I_RST,
  input  logic                     I_FIFO_EMPTY,
  input  logic [WR_DATA_WIDTH-1:0] I_FIFO_DATA,
  input  logic                     I_PAR_EN,
  input  logic                     I_PAR_TYP,
  output logic                     O_R_INC,
  output logic                     O_TX,
  output logic                     O_BUSY
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [WR_DATA_WIDTH-1:0] word_q, word_d;
  logic                     hi_q, hi_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     par_en_q, par_en_d;
  logic                     par_typ_q, par_typ_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic                     r_inc_q, r_inc_d;
  logic                     capture;
  logic [7:0]               byte_d;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    busy_d    = busy_q;
    r_inc_d   = 1'b0;
    capture   = !I_FIFO_EMPTY && ((state_q == IDLE) || ((state_q == STOP) && hi_q));

    case (state_q)
      IDLE: busy_d = 1'b0;
      START: begin
        state_d = DATA;
        cnt_d   = 3'd0;
      end
      DATA: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          cnt_d   = 3'd0;
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
        if (!hi_q) begin
          hi_d    = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture overrides the idle/stop transitions so back-to-back words leave no gap.
    if (capture) begin
      word_d    = I_FIFO_DATA;
      par_en_d  = I_PAR_EN;
      par_typ_d = I_PAR_TYP;
      hi_d      = 1'b0;
      cnt_d     = 3'd0;
      r_inc_d   = 1'b1;
      busy_d    = 1'b1;
      state_d   = START;
    end

    // The line is registered, so it is driven from the state being entered.
    byte_d = hi_d ? word_d[15:8] : word_d[7:0];
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_d[cnt_d];
      PARITY:  tx_d = (^byte_d) ^ par_typ_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST) begin
    if (!I_RST) begin
      state_q   <= IDLE;
      word_q    <= '0;
      hi_q      <= 1'b0;
      cnt_q     <= 3'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      r_inc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      r_inc_q   <= r_inc_d;
    end
  end

  assign O_TX    = tx_q;
  assign O_BUSY  = busy_q;
  assign O_R_INC = r_inc_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_fifo_uart_tx
// Bench for fifo_uart_tx: FIFO model, frame-level reference and directed tests.
// Rev 1.0
// ============================================================================
module tb_fifo_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        par_en;
  logic        par_typ;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        r_inc;
  logic        tx;
  logic        busy;

  logic [15:0] mem [256];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;

  int vectors     = 0;
  int miscompares = 0;

  // Expected per-cycle outputs, packed as {r_inc, busy, tx}
  logic [2:0] seq [$];
  logic       exp_tx   = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_rinc = 1'b0;

  fifo_uart_tx #(.WR_DATA_WIDTH(16)) dut (
    .I_CLK        (clk),
    .I_RST        (rst_n),
    .I_FIFO_EMPTY (fifo_empty),
    .I_FIFO_DATA  (fifo_data),
    .I_PAR_EN     (par_en),
    .I_PAR_TYP    (par_typ),
    .O_R_INC      (r_inc),
    .O_TX         (tx),
    .O_BUSY       (busy)
  );

  always #5 clk = ~clk;

  assign fifo_data  = mem[rd_ptr];
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (r_inc) rd_ptr <= rd_ptr + 8'd1;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void push_frame(input logic [7:0] b, input logic pe, input logic pt, input logic first);
    seq.push_back({first, 1'b1, 1'b0});
    for (int i = 0; i < 8; i++) seq.push_back({2'b01, b[i]});
    if (pe) seq.push_back({2'b01, (^b) ^ pt});
    seq.push_back(3'b011);
  endfunction

  // Reference: each capture expands into the whole word's bit list.
  always @(posedge clk) begin
    if (!rst_n) begin
      seq.delete();
    end else begin
      if (seq.size() > 0) void'(seq.pop_front());
      if (seq.size() == 0 && !fifo_empty) begin
        push_frame(fifo_data[7:0],  par_en, par_typ, 1'b1);
        push_frame(fifo_data[15:8], par_en, par_typ, 1'b0);
      end
    end
    if (seq.size() > 0) {exp_rinc, exp_busy, exp_tx} = seq[0];
    else                {exp_rinc, exp_busy, exp_tx} = 3'b001;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("tx_rst",   {63'd0, tx},    64'd1);
      check("busy_rst", {63'd0, busy},  64'd0);
      check("rinc_rst", {63'd0, r_inc}, 64'd0);
    end else begin
      check("tx",   {63'd0, tx},    {63'd0, exp_tx});
      check("busy", {63'd0, busy},  {63'd0, exp_busy});
      check("rinc", {63'd0, r_inc}, {63'd0, exp_rinc});
    end
  end

  task automatic push(input logic [15:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_rinc();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (r_inc) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rinc_seen", {63'd0, ok}, 64'd1);
  endtask

  task automatic collect(input int n, output logic [63:0] pat);
    pat = '0;
    wait_rinc();
    for (int i = 0; i < n; i++) begin
      pat = {pat[62:0], tx};
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy && fifo_empty) break;
      @(negedge clk);
    end
    check("reach_idle", {62'd0, busy, fifo_empty}, 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [63:0] pat;
    logic [99:0] txr;
    int          busy_cnt;
    int          second;
    int          cnt;

    rst_n   = 1'b0;
    par_en  = 1'b0;
    par_typ = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle with an empty FIFO
    cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cnt += int'(r_inc);
      busy_cnt += int'(busy);
    end
    check("idle_rinc_count", 64'(cnt), 64'd0);
    check("idle_busy_count", 64'(busy_cnt), 64'd0);

    // Single word, no parity
    par_en = 1'b0;
    push(16'hF0F0);
    collect(20, pat);
    check("f0f0_noparity_bits", pat, 64'b00000111110000011111);
    check("f0f0_busy_after", {63'd0, busy}, 64'd0);
    wait_idle();

    // Even parity
    par_en  = 1'b1;
    par_typ = 1'b0;
    push(16'hF0FF);
    collect(22, pat);
    check("f0ff_even_bits", pat, 64'b0111111110100000111101);
    check("f0ff_busy_after", {63'd0, busy}, 64'd0);
    wait_idle();

    // Odd parity, two words back-to-back
    par_typ = 1'b1;
    push(16'h00FF);
    push(16'hF0F0);
    wait_rinc();
    txr = '0;
    busy_cnt = 0;
    second = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      busy_cnt++;
      if (i > 0 && r_inc && second == 0) second = i;
      txr[i] = tx;
      @(negedge clk);
    end
    check("b2b_busy_len", 64'(busy_cnt), 64'd44);
    check("b2b_rinc_gap", 64'(second), 64'd22);
    check("b2b_lo_parity", {63'd0, txr[9]}, 64'd1);
    check("b2b_hi_parity", {63'd0, txr[20]}, 64'd1);
    check("b2b_last_stop", {63'd0, txr[21]}, 64'd1);
    check("b2b_next_start", {63'd0, txr[22]}, 64'd0);
    wait_idle();

    // Config toggled mid-word has no effect
    par_en  = 1'b0;
    par_typ = 1'b0;
    push(16'hF0F0);
    fork
      collect(20, pat);
      begin
        repeat (3) @(negedge clk);
        par_en = 1'b1;
        repeat (5) @(negedge clk);
        par_typ = 1'b1;
        repeat (6) @(negedge clk);
        par_en = 1'b0;
        repeat (2) @(negedge clk);
        par_en = 1'b1;
      end
    join
    check("cfg_change_bits", pat, 64'b00000111110000011111);
    wait_idle();

    // Reset during data bit 3 of the high byte
    par_en  = 1'b1;
    par_typ = 1'b0;
    push(16'hF0FF);
    wait_rinc();
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx",   {63'd0, tx},    64'd1);
    check("rst_mid_busy", {63'd0, busy},  64'd0);
    check("rst_mid_rinc", {63'd0, r_inc}, 64'd0);
    @(negedge clk);
    push(16'($urandom));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cnt += int'(r_inc);
    end
    check("rst_resume_rinc_count", 64'(cnt), 64'd1);
    check("rst_resume_busy", {63'd0, busy}, 64'd0);

    // Randomized traffic with random config changes
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0 && 8'(wr_ptr - rd_ptr) < 8'd6) push(16'($urandom));
      if ($urandom_range(0, 7) == 0) par_en = 1'($urandom);
      if ($urandom_range(0, 7) == 0) par_typ = 1'($urandom);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
